// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

    localparam int unsigned DEFAULT_WIDTH = 5;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle of serial_subtractor; the ovf signal exists only
// when SERIAL_SUB_OVF_EN is defined.
interface serial_subtractor_if
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             b_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             b_out;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;

    modport master (
        output start, a, b, b_in,
        input  busy, done, d, b_out, ovf
    );

    modport slave (
        input  start, a, b, b_in,
        output busy, done, d, b_out, ovf
    );
`else
    modport master (
        output start, a, b, b_in,
        input  busy, done, d, b_out
    );

    modport slave (
        input  start, a, b, b_in,
        output busy, done, d, b_out
    );
`endif

endinterface

// File: rtl/full_subtractor.sv
// Single-bit full subtractor: diff = x - y - bi, with borrow-out bo.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic diff,
    output logic bo
);

    assign diff = x ^ y ^ bi;
    assign bo   = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: d = a - b - b_in over WIDTH cycles, LSB first.
// Optional signed-overflow flag enabled with SERIAL_SUB_OVF_EN.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    serial_subtractor_if.slave  bus
);

    localparam int unsigned            CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]       LAST_BIT = CNT_W'(WIDTH - 1);

    state_e           state_q;
    logic [WIDTH-1:0] a_sr_q;
    logic [WIDTH-1:0] b_sr_q;
    logic [WIDTH-1:0] res_sr_q;
    logic             borrow_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] d_q;
    logic             b_out_q;
    logic             diff;
    logic             bo;
    logic             accept;

    // Requests are taken in IDLE and in the DONE cycle, never mid-operation.
    assign accept = bus.start && (state_q != RUN);

    full_subtractor u_fs (
        .x    (a_sr_q[0]),
        .y    (b_sr_q[0]),
        .bi   (borrow_q),
        .diff (diff),
        .bo   (bo)
    );

`ifdef SERIAL_SUB_OVF_EN
    logic a_msb_q;
    logic b_msb_q;
    logic ovf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            a_msb_q <= bus.a[WIDTH-1];
            b_msb_q <= bus.b[WIDTH-1];
        end else if (state_q == RUN && cnt_q == LAST_BIT) begin
            // diff here is the result MSB.
            ovf_q <= (a_msb_q ^ b_msb_q) & (a_msb_q ^ diff);
        end
    end

    assign bus.ovf = ovf_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_sr_q <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            d_q      <= '0;
            b_out_q  <= 1'b0;
        end else if (accept) begin
            state_q  <= RUN;
            a_sr_q   <= bus.a;
            b_sr_q   <= bus.b;
            res_sr_q <= '0;
            borrow_q <= bus.b_in;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    a_sr_q   <= {1'b0, a_sr_q[WIDTH-1:1]};
                    b_sr_q   <= {1'b0, b_sr_q[WIDTH-1:1]};
                    res_sr_q <= {diff, res_sr_q[WIDTH-1:1]};
                    borrow_q <= bo;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BIT) begin
                        state_q <= DONE;
                        d_q     <= {diff, res_sr_q[WIDTH-1:1]};
                        b_out_q <= bo;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.d     = d_q;
    assign bus.b_out = b_out_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor; ovf checks are
// compiled in when SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor;

    localparam int unsigned W = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // Presents a request for one edge; returns 1 time unit after the accept edge.
    task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = av;
        bus.b     = bv;
        bus.b_in  = bi;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Counts edges until done is seen, bounded so a missing done cannot hang.
    task automatic wait_done(output int cycles);
        cycles = 0;
        while (cycles < 20) begin
            @(posedge clk);
            #1;
            cycles++;
            if (bus.done) return;
        end
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic bi, input int exp_d, input int exp_bo);
        int cyc;
        start_op(av, bv, bi);
        check({tag, "_busy"}, 32'(bus.busy), 32'd1);
        wait_done(cyc);
        check({tag, "_lat"}, 32'(cyc), 32'(W));
        check({tag, "_done"}, 32'(bus.done), 32'd1);
        check({tag, "_busy_lo"}, 32'(bus.busy), 32'd0);
        check({tag, "_d"}, 32'(bus.d), 32'(exp_d));
        check({tag, "_bout"}, 32'(bus.b_out), 32'(exp_bo));
    endtask

    initial begin
        int cyc;
        int seen;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.b_in  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_d", 32'(bus.d), 32'd0);
        check("rst_bout", 32'(bus.b_out), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        check("rst_ovf", 32'(bus.ovf), 32'd0);
`endif

        run_op("t21m7", 5'd21, 5'd7, 1'b0, 14, 0);
        run_op("t3m9", 5'd3, 5'd9, 1'b0, 26, 1);
        run_op("t0m0b", 5'd0, 5'd0, 1'b1, 31, 1);

        // Second request arrives while busy and is held through the done cycle.
        start_op(5'd1, 5'd1, 1'b0);
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.a     = 5'd30;
        bus.b     = 5'd2;
        bus.b_in  = 1'b0;
        wait_done(cyc);
        check("ign_lat", 32'(cyc), 32'd4);
        check("ign_d", 32'(bus.d), 32'd0);
        check("ign_bout", 32'(bus.b_out), 32'd0);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("b2b_done_lo", 32'(bus.done), 32'd0);
        check("b2b_busy", 32'(bus.busy), 32'd1);
        check("b2b_d_held", 32'(bus.d), 32'd0);
        wait_done(cyc);
        check("b2b_lat", 32'(cyc), 32'd5);
        check("b2b_d", 32'(bus.d), 32'd28);
        check("b2b_bout", 32'(bus.b_out), 32'd0);

        // Reset in the third busy cycle discards the operation.
        start_op(5'd10, 5'd3, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_done", 32'(bus.done), 32'd0);
        check("mid_rst_d", 32'(bus.d), 32'd0);
        check("mid_rst_bout", 32'(bus.b_out), 32'd0);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) seen++;
        end
        check("mid_rst_no_done", 32'(seen), 32'd0);

`ifdef SERIAL_SUB_OVF_EN
        run_op("ovf16m1", 5'd16, 5'd1, 1'b0, 15, 0);
        check("ovf16m1_ovf", 32'(bus.ovf), 32'd1);
        run_op("ovf5m3", 5'd5, 5'd3, 1'b0, 2, 0);
        check("ovf5m3_ovf", 32'(bus.ovf), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
